// File: rtl/nec_stack_sequencer.sv
// Push/pop stack sequencer: walks decoder slot masks one slot at a time,
// issuing one word transfer on the stack bus per slot and maintaining SP.
module nec_stack_sequencer #(
    parameter logic [15:0] SP_STEP = 16'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        ready,
    input  logic [15:0] push_mask,
    input  logic [15:0] pop_mask,
    input  logic [15:0] sp_in,
    output logic [15:0] sp_out,
    output logic [3:0]  rd_index,
    input  logic [15:0] rd_data,
    output logic        wb_valid,
    output logic [3:0]  wb_index,
    output logic [15:0] wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req/mem_we/mem_addr/mem_wdata are raised together and held
    // unchanged until a cycle where mem_req=1 and mem_ack=1; that edge completes
    // the transfer and drops mem_req. mem_ack with mem_req=0 has no effect.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_POP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0]  SLOT_SP      = 4'd4;
    localparam logic [3:0]  SLOT_SKIP    = 4'd5;
    localparam logic [15:0] SKIP_BIT     = 16'h0020;

    state_t      state_q;
    logic [15:0] push_q;
    logic [15:0] pop_q;
    logic [15:0] sp_q;
    logic [15:0] sp_cap_q;
    logic        ready_q;
    logic [3:0]  rd_index_q;
    logic        wb_valid_q;
    logic [3:0]  wb_index_q;
    logic [15:0] wb_data_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        done_q;

    logic [3:0]  push_slot;
    logic [3:0]  pop_slot;
    logic [15:0] push_rest;
    logic [15:0] pop_rest;
    logic [15:0] sp_dec;
    logic [15:0] sp_inc;
    logic [15:0] start_push;

    function automatic logic [3:0] lowest_bit(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [3:0] highest_bit(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    always_comb begin
        push_slot  = lowest_bit(push_q);
        pop_slot   = highest_bit(pop_q);
        push_rest  = push_q & ~(16'h0001 << push_slot);
        pop_rest   = pop_q & ~(16'h0001 << pop_slot);
        sp_dec     = sp_q - SP_STEP;
        sp_inc     = sp_q + SP_STEP;
        // Bit 5 never produces a push transfer, so it is dropped at capture.
        start_push = push_mask & ~SKIP_BIT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            push_q      <= 16'h0000;
            pop_q       <= 16'h0000;
            sp_q        <= 16'h0000;
            sp_cap_q    <= 16'h0000;
            ready_q     <= 1'b1;
            rd_index_q  <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_index_q  <= 4'd0;
            wb_data_q   <= 16'h0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            done_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && ready_q) begin
                        push_q     <= start_push;
                        pop_q      <= pop_mask;
                        sp_q       <= sp_in;
                        sp_cap_q   <= sp_in;
                        ready_q    <= 1'b0;
                        rd_index_q <= lowest_bit(start_push);
                        if (push_mask != 16'h0000) begin
                            state_q <= S_PUSH;
                        end else if (pop_mask != 16'h0000) begin
                            state_q <= S_POP;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end

                S_PUSH: begin
                    if (mem_req_q) begin
                        if (mem_ack) begin
                            mem_req_q  <= 1'b0;
                            sp_q       <= sp_dec;
                            push_q     <= push_rest;
                            rd_index_q <= lowest_bit(push_rest);
                            if (push_rest == 16'h0000) begin
                                state_q <= (pop_q != 16'h0000) ? S_POP : S_DONE;
                            end
                        end
                    end else if (push_q == 16'h0000) begin
                        state_q <= (pop_q != 16'h0000) ? S_POP : S_DONE;
                    end else begin
                        // rd_index already points at push_slot, so rd_data is valid now.
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= sp_dec;
                        mem_wdata_q <= (push_slot == SLOT_SP) ? sp_cap_q : rd_data;
                    end
                end

                S_POP: begin
                    if (mem_req_q) begin
                        if (mem_ack) begin
                            mem_req_q <= 1'b0;
                            sp_q      <= sp_inc;
                            pop_q     <= pop_rest;
                            if (pop_slot != SLOT_SP) begin
                                wb_valid_q <= 1'b1;
                                wb_index_q <= pop_slot;
                                wb_data_q  <= mem_rdata;
                            end
                            if (pop_rest == 16'h0000) begin
                                state_q <= S_DONE;
                            end
                        end
                    end else if (pop_q == 16'h0000) begin
                        state_q <= S_DONE;
                    end else if (pop_slot == SLOT_SKIP) begin
                        sp_q  <= sp_inc;
                        pop_q <= pop_rest;
                        if (pop_rest == 16'h0000) begin
                            state_q <= S_DONE;
                        end
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= sp_q;
                    end
                end

                S_DONE: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ready     = ready_q;
    assign sp_out    = sp_q;
    assign rd_index  = rd_index_q;
    assign wb_valid  = wb_valid_q;
    assign wb_index  = wb_index_q;
    assign wb_data   = wb_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nec_stack_sequencer.sv
// Directed bench for nec_stack_sequencer: table of mask sequences with
// hand-computed bus/write-back traces, plus reset, latency and busy-start cases.
module tb_nec_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [15:0] push_mask = 16'h0000;
    logic [15:0] pop_mask = 16'h0000;
    logic [15:0] sp_in = 16'h0000;
    logic [15:0] sp_out;
    logic [3:0]  rd_index;
    logic [15:0] rd_data;
    logic        wb_valid;
    logic [3:0]  wb_index;
    logic [15:0] wb_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        done;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    nec_stack_sequencer #(.SP_STEP(16'd2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .ready     (ready),
        .push_mask (push_mask),
        .pop_mask  (pop_mask),
        .sp_in     (sp_in),
        .sp_out    (sp_out),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .wb_valid  (wb_valid),
        .wb_index  (wb_index),
        .wb_data   (wb_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Register file model: slot n holds 0x1000+n.
    assign rd_data = 16'h1000 + {12'h000, rd_index};

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] d;
    } ev_t;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_WB = 2'd2;

    typedef struct {
        logic [15:0] push;
        logic [15:0] pop;
        logic [15:0] sp;
        int          delay;
        logic [15:0] exp_sp;
    } case_t;

    typedef struct {
        int  cid;
        ev_t ev;
    } tab_ev_t;

    case_t       cases[6];
    tab_ev_t     ev_tab[$];
    logic [33:0] exp_q[$];
    logic [33:0] act_q[$];

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    int done_cnt = 0;
    logic        cap_we;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_ev(input int cid, input logic [1:0] k, input logic [15:0] a, input logic [15:0] d);
        tab_ev_t t;
        t.cid     = cid;
        t.ev.kind = k;
        t.ev.a    = a;
        t.ev.d    = d;
        ev_tab.push_back(t);
    endtask

    // Bus responder and event monitor; all sampling on the falling edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wb_valid) act_q.push_back({K_WB, 12'h000, wb_index, wb_data});
            if (done) done_cnt++;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req) begin
                if (wait_cnt == 0) begin
                    cap_we    = mem_we;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                end else begin
                    check("req_stable", {1'b0, mem_we, mem_addr, mem_wdata},
                          {1'b0, cap_we, cap_addr, cap_wdata});
                end
                if (wait_cnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_addr;
                    if (mem_we) act_q.push_back({K_WR, mem_addr, mem_wdata});
                    else        act_q.push_back({K_RD, mem_addr, mem_addr});
                end
                wait_cnt++;
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 34'(act_q.size()), 34'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < act_q.size()) check($sformatf("%s_ev%0d", tag, i), act_q[i], exp_q[i]);
        end
    endtask

    task automatic run_case(input int c);
        int n;
        exp_q.delete();
        act_q.delete();
        foreach (ev_tab[i]) begin
            if (ev_tab[i].cid == c) exp_q.push_back(ev_tab[i].ev);
        end
        ack_delay = cases[c].delay;
        n = 0;
        while (!ready && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        done_cnt  = 0;
        push_mask = cases[c].push;
        pop_mask  = cases[c].pop;
        sp_in     = cases[c].sp;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check($sformatf("case%0d_done_seen", c), 34'(done_cnt != 0), 34'd1);
        repeat (4) @(posedge clk);
        #1;
        compare_events($sformatf("case%0d", c));
        check($sformatf("case%0d_sp", c), 34'(sp_out), 34'(cases[c].exp_sp));
        check($sformatf("case%0d_done_once", c), 34'(done_cnt), 34'd1);
        check($sformatf("case%0d_ready", c), 34'(ready), 34'd1);
    endtask

    initial begin
        int n;

        cases[0] = '{16'h00FF, 16'h0000, 16'h0100, 0, 16'h00F2};
        cases[1] = '{16'h0000, 16'h01FF, 16'h00F0, 0, 16'h0102};
        cases[2] = '{16'h4C00, 16'h0000, 16'h0002, 3, 16'hFFFC};
        cases[3] = '{16'h0000, 16'h0000, 16'h1234, 0, 16'h1234};
        cases[4] = '{16'h8000, 16'h0001, 16'h0200, 1, 16'h0200};
        cases[5] = '{16'h0000, 16'h0020, 16'hFFFE, 0, 16'h0000};

        add_ev(0, K_WR, 16'h00FE, 16'h1000);
        add_ev(0, K_WR, 16'h00FC, 16'h1001);
        add_ev(0, K_WR, 16'h00FA, 16'h1002);
        add_ev(0, K_WR, 16'h00F8, 16'h1003);
        add_ev(0, K_WR, 16'h00F6, 16'h0100);
        add_ev(0, K_WR, 16'h00F4, 16'h1006);
        add_ev(0, K_WR, 16'h00F2, 16'h1007);

        add_ev(1, K_RD, 16'h00F0, 16'h00F0);  add_ev(1, K_WB, 16'd8, 16'h00F0);
        add_ev(1, K_RD, 16'h00F2, 16'h00F2);  add_ev(1, K_WB, 16'd7, 16'h00F2);
        add_ev(1, K_RD, 16'h00F4, 16'h00F4);  add_ev(1, K_WB, 16'd6, 16'h00F4);
        add_ev(1, K_RD, 16'h00F8, 16'h00F8);
        add_ev(1, K_RD, 16'h00FA, 16'h00FA);  add_ev(1, K_WB, 16'd3, 16'h00FA);
        add_ev(1, K_RD, 16'h00FC, 16'h00FC);  add_ev(1, K_WB, 16'd2, 16'h00FC);
        add_ev(1, K_RD, 16'h00FE, 16'h00FE);  add_ev(1, K_WB, 16'd1, 16'h00FE);
        add_ev(1, K_RD, 16'h0100, 16'h0100);  add_ev(1, K_WB, 16'd0, 16'h0100);

        add_ev(2, K_WR, 16'h0000, 16'h100A);
        add_ev(2, K_WR, 16'hFFFE, 16'h100B);
        add_ev(2, K_WR, 16'hFFFC, 16'h100E);

        add_ev(4, K_WR, 16'h01FE, 16'h100F);
        add_ev(4, K_RD, 16'h01FE, 16'h01FE);
        add_ev(4, K_WB, 16'd0, 16'h01FE);

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst_ready",    34'(ready),     34'd1);
        check("rst_sp",       34'(sp_out),    34'd0);
        check("rst_mem_req",  34'(mem_req),   34'd0);
        check("rst_mem_we",   34'(mem_we),    34'd0);
        check("rst_mem_addr", 34'(mem_addr),  34'd0);
        check("rst_wdata",    34'(mem_wdata), 34'd0);
        check("rst_wb",       34'({wb_valid, wb_index, wb_data}), 34'd0);
        check("rst_rd_index", 34'(rd_index),  34'd0);
        check("rst_done",     34'(done),      34'd0);
        check("rst_state",    34'(dbg_state), 34'd0);
        reset_n = 1'b1;

        for (int c = 0; c < 6; c++) run_case(c);

        // Empty masks: done exactly one cycle after the accepting edge.
        @(negedge clk);
        done_cnt  = 0;
        push_mask = 16'h0000;
        pop_mask  = 16'h0000;
        sp_in     = 16'hABCD;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("lat_done_early", 34'(done),  34'd0);
        check("lat_busy",       34'(ready), 34'd0);
        @(negedge clk);
        check("lat_done",       34'(done),    34'd1);
        check("lat_no_req",     34'(mem_req), 34'd0);
        @(negedge clk);
        check("lat_done_off",   34'(done),   34'd0);
        check("lat_ready",      34'(ready),  34'd1);
        check("lat_sp",         34'(sp_out), 34'hABCD);

        // Start while busy is ignored.
        exp_q.delete();
        act_q.delete();
        exp_q.push_back({K_WR, 16'h000E, 16'h1000});
        ack_delay = 2;
        @(negedge clk);
        done_cnt  = 0;
        push_mask = 16'h0001;
        pop_mask  = 16'h0000;
        sp_in     = 16'h0010;
        start     = 1'b1;
        @(posedge clk);
        #1;
        pop_mask  = 16'hFFFF;
        sp_in     = 16'h5555;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        compare_events("busy");
        check("busy_sp",   34'(sp_out),   34'h000E);
        check("busy_done", 34'(done_cnt), 34'd1);

        // Asynchronous reset in the middle of a held push request.
        act_q.delete();
        ack_delay = 50;
        @(negedge clk);
        push_mask = 16'h0003;
        pop_mask  = 16'h0000;
        sp_in     = 16'h0040;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_req_seen", 34'(mem_req), 34'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_req",   34'(mem_req), 34'd0);
        check("mid_rst_ready", 34'(ready),   34'd1);
        check("mid_rst_sp",    34'(sp_out),  34'd0);
        check("mid_rst_addr",  34'(mem_addr), 34'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_idle", 34'({mem_req, done, ready}), 34'b001);
        check("post_rst_no_ev", 34'(act_q.size()), 34'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
